// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and flat-bus unpack helper for regfile_mp
package regfile_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_FLAT_W = 128;

    // Extract field k of width w from a flat bus, zero-extended to RF_FLAT_W.
    function automatic logic [RF_FLAT_W-1:0] rf_unpack(input logic [RF_FLAT_W-1:0] flat,
                                                       input int k, input int w);
        logic [RF_FLAT_W-1:0] mask;
        mask = (RF_FLAT_W'(1) << w) - RF_FLAT_W'(1);
        return (flat >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write, read, issue and write-notify signals of regfile_mp
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [DEPTH-1:0]       wr_onehot;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
        input  rd_data, rd_busy, wr_onehot
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
        output rd_data, rd_busy, wr_onehot
    );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with zero-reg, bypass and busy lookup
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [WIDTH-1:0] mem_i [DEPTH],
    input  logic [DEPTH-1:0] busy_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             wr_ok_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_busy_o
);

    logic hit;

    always_comb begin
        hit       = (BYPASS != 0) && wr_ok_i && (wr_addr_i == rd_addr_i);
        rd_data_o = mem_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
        // wr_ok_i is already low for register 0, so the zero override never races the bypass
        if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else if (hit) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass and busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] onehot_q;
    logic [DEPTH-1:0] onehot_d;
    logic [DEPTH-1:0] iss_dec;
    logic             wr_ok;
    logic             iss_ok;

    always_comb begin
        wr_ok    = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
        iss_ok   = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));
        onehot_d = wr_ok  ? (DEPTH'(1) << bus.wr_addr)  : '0;
        iss_dec  = iss_ok ? (DEPTH'(1) << bus.iss_addr) : '0;
        // a new producer issued alongside the writeback keeps the register busy
        busy_d   = (busy_q & ~onehot_d) | iss_dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q   <= '0;
            onehot_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (onehot_d[i]) begin
                    mem_q[i] <= bus.wr_data;
                end
            end
            busy_q   <= busy_d;
            onehot_q <= onehot_d;
        end
    end

    assign bus.wr_onehot = onehot_q;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = AW'(rf_unpack(RF_FLAT_W'(bus.rd_addr), k, AW));

        regfile_read_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .mem_i    (mem_q),
            .busy_i   (busy_q),
            .rd_addr_i(ra),
            .wr_ok_i  (wr_ok),
            .wr_addr_i(bus.wr_addr),
            .wr_data_i(bus.wr_data),
            .rd_data_o(bus.rd_data[k*WIDTH +: WIDTH]),
            .rd_busy_o(bus.rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp in two zero-reg/bypass configurations
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus0 ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus1 ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        int          d;
        string       name;
        logic [63:0] data;
        logic [1:0]  busy;
        logic [31:0] oh;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic ie, input logic [4:0] ia);
        bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd;
        bus0.rd_addr = {ra1, ra0}; bus0.iss_en = ie; bus0.iss_addr = ia;
        bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd;
        bus1.rd_addr = {ra1, ra0}; bus1.iss_en = ie; bus1.iss_addr = ia;
    endtask

    task automatic push(input int d, input string n, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [1:0] b, input logic [31:0] oh);
        exp_t e;
        e.d = d; e.name = n; e.data = {p1, p0}; e.busy = b; e.oh = oh;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: everything queued during a cycle is compared at the following falling edge.
    initial begin
        exp_t        e;
        logic [63:0] ad;
        logic [1:0]  ab;
        logic [31:0] ao;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.d == 0) begin
                    ad = bus0.rd_data; ab = bus0.rd_busy; ao = bus0.wr_onehot;
                end else begin
                    ad = bus1.rd_data; ab = bus1.rd_busy; ao = bus1.wr_onehot;
                end
                check($sformatf("dut%0d %s rd_data", e.d, e.name), ad, e.data);
                check($sformatf("dut%0d %s rd_busy", e.d, e.name), 64'(ab), 64'(e.busy));
                check($sformatf("dut%0d %s wr_onehot", e.d, e.name), 64'(ao), 64'(e.oh));
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            drive(1, 5'(a), 32'hFFFF_FFFF, 0, 0, 0, 0);
            tick;
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        tick;
        drive(0, 0, 0, 0, 0, 1, 2);
        tick;

        drive(0, 0, 0, 1, 2, 0, 0);
        push(0, "prefill", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0);
        push(1, "prefill", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0);
        tick;
        rst_n = 1'b0;
        push(0, "async_reset", 0, 0, 2'b00, 0);
        push(1, "async_reset", 0, 0, 2'b00, 0);
        tick; tick;
        rst_n = 1'b1;

        drive(1, 5, 32'hDEAD_BEEF, 5, 5, 0, 0);
        push(0, "wr_r5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0);
        push(1, "wr_r5", 0, 0, 2'b00, 0);
        tick;
        drive(0, 0, 0, 5, 5, 0, 0);
        push(0, "rd_r5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 32'h0000_0020);
        push(1, "rd_r5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 32'h0000_0020);
        tick;

        drive(1, 0, 32'h1234, 0, 0, 0, 0);
        push(0, "wr_r0", 0, 0, 2'b00, 0);
        push(1, "wr_r0", 0, 0, 2'b00, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        push(0, "rd_r0", 0, 0, 2'b00, 0);
        push(1, "rd_r0", 32'h1234, 32'h1234, 2'b00, 32'h0000_0001);
        tick;

        drive(1, 7, 32'hA5A5, 7, 5, 0, 0);
        push(0, "bypass_r7", 32'hA5A5, 32'hDEAD_BEEF, 2'b00, 0);
        push(1, "bypass_r7", 0, 32'hDEAD_BEEF, 2'b00, 0);
        tick;
        drive(0, 0, 0, 7, 5, 0, 0);
        push(0, "rd_r7", 32'hA5A5, 32'hDEAD_BEEF, 2'b00, 32'h0000_0080);
        push(1, "rd_r7", 32'hA5A5, 32'hDEAD_BEEF, 2'b00, 32'h0000_0080);
        tick;

        drive(0, 0, 0, 9, 9, 1, 9);
        push(0, "iss_r9", 0, 0, 2'b00, 0);
        push(1, "iss_r9", 0, 0, 2'b00, 0);
        tick;
        drive(1, 9, 32'h99, 9, 9, 1, 9);
        push(0, "wr_iss_r9", 32'h99, 32'h99, 2'b00, 0);
        push(1, "wr_iss_r9", 0, 0, 2'b11, 0);
        tick;
        drive(1, 9, 32'h9A, 9, 9, 0, 0);
        push(0, "wr_only_r9", 32'h9A, 32'h9A, 2'b00, 32'h0000_0200);
        push(1, "wr_only_r9", 32'h99, 32'h99, 2'b11, 32'h0000_0200);
        tick;
        drive(0, 0, 0, 9, 9, 0, 0);
        push(0, "idle_r9", 32'h9A, 32'h9A, 2'b00, 32'h0000_0200);
        push(1, "idle_r9", 32'h9A, 32'h9A, 2'b00, 32'h0000_0200);
        tick;

        drive(1, 3, 32'h55, 3, 3, 1, 3);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        drive(0, 0, 0, 3, 3, 0, 0);
        push(0, "reset_mid_wr", 0, 0, 2'b00, 0);
        push(1, "reset_mid_wr", 0, 0, 2'b00, 0);
        tick;
        drive(0, 0, 0, 5, 7, 0, 0);
        push(0, "post_reset", 0, 0, 2'b00, 0);
        push(1, "post_reset", 0, 0, 2'b00, 0);
        tick;

        tick; tick;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
